// File: rtl/mux_pkg.sv
// mux_pkg: shared arbitration modes and channel-slice helper for rr_mux_arbiter.
package mux_pkg;
  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;
  function automatic int unsigned ch_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating priority encoder, searching from ptr upward with wrap.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      int unsigned c;
      c = (int'(ptr) + k) % NUM_CH;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = SEL_W'(c);
      end
    end
  end
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: N-way valid/ready mux with round-robin or fixed-select arbitration
// feeding a one-entry output register.
module rr_mux_arbiter
  import mux_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);
  logic [NUM_CH-1:0] rr_gnt, fix_gnt, gnt;
  logic [SEL_W-1:0]  rr_idx, win_idx, ptr_q, ptr_d, ch_q, ch_d;
  logic              rr_any, can_load, xfer, valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;

  rr_pick #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_pick (
    .req(in_valid), .ptr(ptr_q), .gnt(rr_gnt), .idx(rr_idx), .any(rr_any)
  );

  // Out-of-range sel shifts the bit out entirely, yielding no grant.
  assign fix_gnt  = (NUM_CH'(1) << sel) & in_valid;
  assign gnt      = (mode == MODE_FIXED) ? fix_gnt : (rr_any ? rr_gnt : '0);
  assign win_idx  = (mode == MODE_FIXED) ? sel : rr_idx;
  assign can_load = ~valid_q | out_ready;
  assign in_ready = gnt & {NUM_CH{can_load & ~reset}};
  assign xfer     = |in_ready;

  always_comb begin
    valid_d = xfer | (valid_q & ~out_ready);
    data_d  = xfer ? in_data[ch_lsb(int'(win_idx), WIDTH) +: WIDTH] : data_q;
    ch_d    = xfer ? win_idx : ch_q;
    ptr_d   = (xfer && mode == MODE_RR)
            ? ((win_idx == SEL_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Parametrised, registered N-way multiplexer that succeeds the 2-way combinational mux. It arbitrates among NUM_CH valid/ready input channels and forwards the winner's data into a one-entry output register. Arbitration is round-robin or a fixed externally-selected channel. It is used where several datapath sources contend for one bus, for example ALU result, memory read data and immediate feeding the register-file write port.

Parameters:
WIDTH, 16, data width per channel in bits (>=1)
NUM_CH, 4, number of input channels (>=2)
SEL_W, $clog2(NUM_CH), width of channel index (derived; do not override)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
mode  input  1  0 = round-robin arbitration, 1 = fixed select via sel
sel  input  SEL_W  channel index used when mode=1
in_valid  input  NUM_CH  per-channel request; bit i belongs to channel i
in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_ready  output  NUM_CH  per-channel accept; at most one bit high
out_valid  output  1  output register holds data
out_data  output  WIDTH  registered winning data
out_ch  output  SEL_W  index of the channel that supplied out_data
out_ready  input  1  downstream consumer accepts out_data

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- Reset (sampled high at a clk edge):
  - out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0.
  - in_ready is forced to 0 for every cycle reset is high.
  - Reset mid-transfer discards the held word, with no handshake.
- Output register:
  - can_load = ~out_valid | out_ready.
  - A transfer on channel i occurs when in_valid[i] & in_ready[i]. The register then loads in_data[i], sets out_ch=i and out_valid=1 on the same edge.
  - Latency is 1 cycle from input handshake to out_valid.
- Drain: when out_valid & out_ready and no transfer happens, out_valid goes to 0 on the edge. Simultaneous drain plus load gives back-to-back throughput of 1 word per cycle.
- Stall: when out_valid=1 and out_ready=0:
  - out_data and out_ch stay stable.
  - all in_ready bits are 0.
- Grant, combinational:
  - in_ready[i] = grant[i] & can_load & ~reset.
  - grant is one-hot or all-zero.
- Round-robin, mode=0:
  - grant goes to the first valid channel searching ptr, ptr+1, ... NUM_CH-1, 0, ... ptr-1.
  - On a transfer from channel i, ptr becomes (i+1) mod NUM_CH. Channel NUM_CH-1 wraps ptr to 0.
  - ptr does not change without a transfer.
  - No channel waits more than NUM_CH-1 transfers while holding in_valid high.
- Fixed, mode=1:
  - grant[sel] = in_valid[sel]; all other channels get no grant.
  - sel >= NUM_CH (non-power-of-2 NUM_CH) gives no grant.
  - ptr is held in fixed mode.
- Mode or sel changes take effect combinationally, in the same cycle's grant. No state is flushed.
- No valid inputs: no transfer and ptr unchanged.
- Input rules:
  - Channels must hold in_valid and in_data stable until accepted.
  - The block does not depend on in_data of unselected channels.

Decomposition:
- Shared package mux_pkg holds:
  - MODE_RR=1'b0 and MODE_FIXED=1'b1
  - a function for channel-slice extraction.
- Sub-module rr_pick: combinational rotating priority encoder.
  - inputs: req[NUM_CH], ptr[SEL_W]
  - outputs: one-hot gnt[NUM_CH], idx[SEL_W], any
  - instantiated once.
- The top level holds the output register, ptr register and mode mux.

Test Plan:
1. Reset: assert reset 2 cycles with all in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_ch=0. First cycle after release grants ch0.
2. Round-robin fairness: mode=0, out_ready=1, in_valid=4'b1111 held, data ch_i=16'hA000+i, 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with out_data matching, and out_valid high continuously from cycle 1.
3. Wrap and skip: mode=0, ptr=3 (after a ch2 transfer), in_valid=4'b0101 -> grant ch0 then ch2; ptr ends at 3.
4. Back-pressure: out_ready=0 with out_valid=1 holding 16'hA001 for 5 cycles while in_valid=4'b1111 -> in_ready=0, out_data stays 16'hA001. Raise out_ready -> next edge loads the next round-robin channel with no bubble.
5. Fixed mode: mode=1, sel=2, in_valid=4'b1011 -> no transfer. Set in_valid[2]=1 -> out_ch=2 next cycle. sel=3 with ch3 valid -> ch3 only, and ptr is unchanged on return to mode=0.
6. Reset mid-stream: during test 2, assert reset for 1 cycle with out_valid=1 -> out_valid=0 and ptr=0 next cycle; the discarded word never appears on the output.
